vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It is the successor to the fixed 640x480 timer and drives the display datapath and the sprite/glyph renderers. Porches, sync widths and sync polarities are configurable, and a clock-divider pixel strobe removes the need for a separate pixel clock. It adds active-area coordinates, line/frame start pulses, a freeze enable, and correct vertical porch/sync timing.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync
VS_POL, 0, asserted level of vsync
CLK_DIV, 2, clk cycles per pixel (>=1)
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  system clock
clear  input  1  asynchronous active-low reset
en  input  1  run enable; low freezes all state
pix_stb  output  1  one-clk pulse per pixel period
hsync  output  1  horizontal sync, level per HS_POL
vsync  output  1  vertical sync, level per VS_POL
bright  output  1  high inside the active area
hcount  output  CNT_W  raw horizontal position, 0..H_TOTAL-1
vcount  output  CNT_W  raw vertical position, 0..V_TOTAL-1
xpos  output  CNT_W  active-area x, 0..H_ACTIVE-1; 0 outside the active area
ypos  output  CNT_W  active-area y, 0..V_ACTIVE-1; 0 outside the active area
line_start  output  1  one-clk pulse when hcount wraps to 0
frame_start  output  1  one-clk pulse when hcount and vcount both wrap to 0

Behaviour:
- Derived values: H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOTAL likewise (525). HA0=H_SYNC+H_BP (144); VA0=V_SYNC+V_BP (35).
- Region order, horizontal and vertical: sync [0,SYNC), back porch, active [A0,A0+ACTIVE), front porch to TOTAL-1.
- Reset (clear=0, async): div counter=0; hcount=vcount=0; xpos=ypos=0; hsync=HS_POL; vsync=VS_POL; bright=0; pix_stb=line_start=frame_start=0.
- Divider: runs 0..CLK_DIV-1 while en=1. pix_stb=1 for the single clk in which the divider equals CLK_DIV-1. With CLK_DIV=1, pix_stb is constantly 1 while en=1.
- Count advance: happens only on the edge following a pix_stb cycle.
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount advances.
  - vcount wraps to 0 after V_TOTAL-1.
- Output timing: all outputs are registered and updated on the same edge as the counters. hsync, vsync, bright, xpos and ypos always decode the hcount/vcount currently presented, with zero relative skew.
- Decode:
  - hsync = HS_POL when hcount<H_SYNC, else ~HS_POL.
  - vsync = VS_POL when vcount<V_SYNC, else ~VS_POL.
  - bright = 1 when hcount is in [HA0,HA0+H_ACTIVE) and vcount is in [VA0,VA0+V_ACTIVE).
  - xpos = hcount-HA0 and ypos = vcount-VA0 when bright=1; both are 0 otherwise.
- Strobe pulses: line_start is high for exactly one clk after each edge that loads hcount=0. frame_start is high for the same clk when vcount=0 is also loaded. Neither pulse is asserted by reset itself.
- en=0: divider, counters and all level outputs hold; pix_stb, line_start and frame_start are forced to 0. Resumption continues from the held divider value, with no skipped or repeated pixel.
- Reset mid-frame: everything returns immediately to the reset values, and the first pixel after release is (0,0).
- Arithmetic: unsigned CNT_W, no overflow possible under the CNT_W rule. Elaboration fails if 2**CNT_W < max(H_TOTAL,V_TOTAL) or CLK_DIV<1.

Test Plan:
- Defaults, release reset with en=1 → pix_stb every 2nd clk; hcount steps 0..799 then 0; line_start pulses every 1600 clk; frame_start pulses every 840000 clk.
- Defaults, one line → hsync low for hcount 0..95, high for 96..799; with vcount=35, bright high exactly for hcount 144..783, and xpos=0 at 144 and 639 at 783.
- Vertical pass → vsync low only for vcount 0..1; bright never high for vcount<35 or >514; ypos=479 at vcount 514; vcount wraps 524→0 together with frame_start.
- HS_POL=1, VS_POL=1, CLK_DIV=1 → sync pulses inverted; pix_stb continuously high; hcount increments every clk.
- en dropped at hcount=300 for 7 clk → all outputs frozen and no strobes; after re-enable hcount continues 300→301 with no gap or duplicate.
- clear asserted at hcount=500, vcount=200 → outputs go to reset values asynchronously, before the next clk edge; counting restarts from 0,0 after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with an internal pixel-rate divider.
// Counters and every decoded output are registered on the same edge, so sync, blank and coordinates never skew.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CLK_DIV  = 2,
   parameter int   CNT_W    = 10
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   output logic             pix_stb,
   output logic             hsync,
   output logic             vsync,
   output logic             bright,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic [CNT_W-1:0] xpos,
   output logic [CNT_W-1:0] ypos,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HA0     = H_SYNC + H_BP;
   localparam int VA0     = V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HA0_C    = CNT_W'(HA0);
   localparam logic [CNT_W-1:0] VA0_C    = CNT_W'(VA0);
   // Region bounds are one bit wider so an active area ending exactly at 2**CNT_W still compares correctly.
   localparam logic [CNT_W:0]   H_SYNC_W = (CNT_W+1)'(H_SYNC);
   localparam logic [CNT_W:0]   V_SYNC_W = (CNT_W+1)'(V_SYNC);
   localparam logic [CNT_W:0]   HA0_W    = (CNT_W+1)'(HA0);
   localparam logic [CNT_W:0]   HA1_W    = (CNT_W+1)'(HA0 + H_ACTIVE);
   localparam logic [CNT_W:0]   VA0_W    = (CNT_W+1)'(VA0);
   localparam logic [CNT_W:0]   VA1_W    = (CNT_W+1)'(VA0 + V_ACTIVE);

   if ((2**CNT_W) < H_TOTAL || (2**CNT_W) < V_TOTAL || CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_timing_gen: CNT_W too small for the raster or CLK_DIV < 1");
   end

   logic [DIV_W-1:0] r_div;
   logic             r_pix_stb;
   logic [CNT_W-1:0] r_hcount;
   logic [CNT_W-1:0] r_vcount;
   logic [CNT_W-1:0] r_xpos;
   logic [CNT_W-1:0] r_ypos;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_bright;
   logic             r_line;
   logic             r_frame;

   logic             w_adv;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic [DIV_W-1:0] w_div_nx;
   logic [CNT_W-1:0] w_hcount_nx;
   logic [CNT_W-1:0] w_vcount_nx;
   logic             w_h_act;
   logic             w_v_act;

   // Next divider/counter values and the decode of the position about to be presented.
   always_comb begin
      w_adv       = r_pix_stb & en;
      w_h_wrap    = (r_hcount == H_LAST);
      w_v_wrap    = (r_vcount == V_LAST);
      w_div_nx    = (r_div == DIV_LAST) ? DIV_W'(0) : r_div + DIV_W'(1);
      w_hcount_nx = r_hcount;
      w_vcount_nx = r_vcount;
      if (w_adv) begin
         if (w_h_wrap) begin
            w_hcount_nx = CNT_W'(0);
            w_vcount_nx = w_v_wrap ? CNT_W'(0) : r_vcount + CNT_W'(1);
         end else begin
            w_hcount_nx = r_hcount + CNT_W'(1);
         end
      end else begin
         w_hcount_nx = r_hcount;
      end
      w_h_act = ({1'b0, w_hcount_nx} >= HA0_W) && ({1'b0, w_hcount_nx} < HA1_W);
      w_v_act = ({1'b0, w_vcount_nx} >= VA0_W) && ({1'b0, w_vcount_nx} < VA1_W);
   end

   // State and output registers; a low en holds everything except the single-cycle pulses.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_div     <= DIV_W'(0);
         r_pix_stb <= 1'b0;
         r_hcount  <= CNT_W'(0);
         r_vcount  <= CNT_W'(0);
         r_xpos    <= CNT_W'(0);
         r_ypos    <= CNT_W'(0);
         r_hsync   <= HS_POL;
         r_vsync   <= VS_POL;
         r_bright  <= 1'b0;
         r_line    <= 1'b0;
         r_frame   <= 1'b0;
      end else if (en) begin
         r_div     <= w_div_nx;
         r_pix_stb <= (w_div_nx == DIV_LAST);
         r_hcount  <= w_hcount_nx;
         r_vcount  <= w_vcount_nx;
         r_hsync   <= ({1'b0, w_hcount_nx} < H_SYNC_W) ? HS_POL : ~HS_POL;
         r_vsync   <= ({1'b0, w_vcount_nx} < V_SYNC_W) ? VS_POL : ~VS_POL;
         r_bright  <= w_h_act & w_v_act;
         r_xpos    <= (w_h_act & w_v_act) ? (w_hcount_nx - HA0_C) : CNT_W'(0);
         r_ypos    <= (w_h_act & w_v_act) ? (w_vcount_nx - VA0_C) : CNT_W'(0);
         r_line    <= w_adv & w_h_wrap;
         r_frame   <= w_adv & w_h_wrap & w_v_wrap;
      end else begin
         r_line    <= 1'b0;
         r_frame   <= 1'b0;
      end
   end

   // The divider phase is held while disabled, so gating the strobes by en resumes without a lost pixel.
   assign pix_stb     = r_pix_stb & en;
   assign line_start  = r_line & en;
   assign frame_start = r_frame & en;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign bright      = r_bright;
   assign hcount      = r_hcount;
   assign vcount      = r_vcount;
   assign xpos        = r_xpos;
   assign ypos        = r_ypos;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance and a tiny inverted-polarity CLK_DIV=1 instance.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic clear;
   logic en;
   always #5 clk = ~clk;

   logic       stb0, hs0, vs0, br0, ls0, fs0;
   logic [9:0] hc0, vc0, x0, y0;
   logic       stb1, hs1, vs1, br1, ls1, fs1;
   logic [3:0] hc1, vc1, x1, y1;

   vga_timing_gen u_dut0 (
      .clk(clk), .clear(clear), .en(en), .pix_stb(stb0), .hsync(hs0), .vsync(vs0),
      .bright(br0), .hcount(hc0), .vcount(vc0), .xpos(x0), .ypos(y0),
      .line_start(ls0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CNT_W(4)
   ) u_dut1 (
      .clk(clk), .clear(clear), .en(en), .pix_stb(stb1), .hsync(hs1), .vsync(vs1),
      .bright(br1), .hcount(hc1), .vcount(vc1), .xpos(x1), .ypos(y1),
      .line_start(ls1), .frame_start(fs1)
   );

   typedef struct {
      logic stb, hs, vs, br, ls, fs;
      int   h, v, x, y;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_edges;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   // Pixels completed after n enabled edges since reset; the first strobe needs one edge to appear.
   function automatic int pix_count(int n, int cd);
      if (n <= 0) return 0;
      if (cd == 1) return n - 1;
      return n / cd;
   endfunction

   function automatic exp_t model(int n, logic en_now, int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp,
                                  logic hpol, logic vpol, int cd);
      exp_t e;
      int   ht, vt, ha0, va0, p;
      logic adv, nxt;
      ht  = hsw + hbp + ha + hfp;
      vt  = vsw + vbp + va + vfp;
      ha0 = hsw + hbp;
      va0 = vsw + vbp;
      p   = pix_count(n, cd) % (ht * vt);
      adv = (n >= 1) && (pix_count(n, cd) != pix_count(n - 1, cd));
      nxt = pix_count(n + 1, cd) != pix_count(n, cd);
      e.h   = p % ht;
      e.v   = p / ht;
      e.stb = en_now && nxt;
      e.hs  = (e.h < hsw) ? hpol : ~hpol;
      e.vs  = (e.v < vsw) ? vpol : ~vpol;
      e.br  = (e.h >= ha0) && (e.h < ha0 + ha) && (e.v >= va0) && (e.v < va0 + va);
      e.x   = e.br ? e.h - ha0 : 0;
      e.y   = e.br ? e.v - va0 : 0;
      e.ls  = en_now && adv && (e.h == 0);
      e.fs  = e.ls && (e.v == 0);
      return e;
   endfunction

   function automatic exp_t model0(int n, logic en_now);
      return model(n, en_now, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2);
   endfunction

   function automatic exp_t model1(int n, logic en_now);
      return model(n, en_now, 8, 2, 3, 2, 6, 2, 2, 3, 1'b1, 1'b1, 1);
   endfunction

   task automatic cap0(output exp_t a);
      a.stb = stb0; a.hs = hs0; a.vs = vs0; a.br = br0; a.ls = ls0; a.fs = fs0;
      a.h = int'(hc0); a.v = int'(vc0); a.x = int'(x0); a.y = int'(y0);
   endtask

   task automatic cap1(output exp_t a);
      a.stb = stb1; a.hs = hs1; a.vs = vs1; a.br = br1; a.ls = ls1; a.fs = fs1;
      a.h = int'(hc1); a.v = int'(vc1); a.x = int'(x1); a.y = int'(y1);
   endtask

   task automatic check(string name, exp_t a, exp_t e);
      n_checks++;
      if (a.stb !== e.stb || a.hs !== e.hs || a.vs !== e.vs || a.br !== e.br ||
          a.ls !== e.ls || a.fs !== e.fs || a.h != e.h || a.v != e.v || a.x != e.x || a.y != e.y) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got stb=%0b hs=%0b vs=%0b br=%0b ls=%0b fs=%0b h=%0d v=%0d x=%0d y=%0d want stb=%0b hs=%0b vs=%0b br=%0b ls=%0b fs=%0b h=%0d v=%0d x=%0d y=%0d",
                  name, cyc, a.stb, a.hs, a.vs, a.br, a.ls, a.fs, a.h, a.v, a.x, a.y,
                  e.stb, e.hs, e.vs, e.br, e.ls, e.fs, e.h, e.v, e.x, e.y);
      end
   endtask

   // Drive inputs for the coming edge and queue what both instances must show after it.
   task automatic step(logic en_v);
      en = en_v;
      if (clear && en_v) n_edges++;
      q0.push_back(model0(n_edges, en_v));
      q1.push_back(model1(n_edges, en_v));
   endtask

   // Monitor: after each active edge, compare presented outputs against the oldest queued expectation.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            cap0(a);
            check("dut0", a, e);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            cap1(a);
            check("dut1", a, e);
         end
      end
   end

   initial begin
      exp_t last0, a;
      int   drop_cnt;
      bit   dropped;
      int   guard;
      clear    = 1'b0;
      en       = 1'b0;
      n_edges  = 0;
      drop_cnt = 0;
      dropped  = 1'b0;
      guard    = 0;
      @(negedge clk);
      step(1'b0);
      @(negedge clk);
      step(1'b1);
      @(negedge clk);
      clear = 1'b1;
      step(1'b1);
      last0 = model0(n_edges, 1'b1);
      // Run until the default raster is a couple of lines into its active area.
      while (last0.v < 37 && guard < 85000) begin
         @(negedge clk);
         guard++;
         if (drop_cnt > 0) begin
            drop_cnt--;
            step(1'b0);
         end else if (!dropped && last0.h == 300 && last0.v == 0) begin
            dropped  = 1'b1;
            drop_cnt = 6;
            step(1'b0);
         end else begin
            step($urandom_range(15) != 0);
         end
         last0 = model0(n_edges, en);
      end
      if (last0.v < 37) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_budget got v=%0d want v>=37", last0.v);
      end
      // Asynchronous clear between edges: outputs must return to reset values before any edge.
      @(negedge clk);
      en = 1'b1;
      #2 clear = 1'b0;
      #1;
      n_edges = 0;
      cap0(a);
      check("dut0_async_clear", a, model0(0, en));
      cap1(a);
      check("dut1_async_clear", a, model1(0, en));
      step(1'b1);
      repeat (2) begin
         @(negedge clk);
         step(1'b1);
      end
      @(negedge clk);
      clear = 1'b1;
      step(1'b1);
      repeat (3000) begin
         @(negedge clk);
         step($urandom_range(7) != 0);
      end
      @(posedge clk);
      #3;
      n_checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
